// File: rtl/fifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_pop_ctrl
//   Per-FIFO pop sequencer that sits directly after the pop scheduler. Each
//   lane takes a one-cycle need_pop pulse with a pop count. It then issues
//   exactly that many pops toward its PE row. A lane pops only in cycles where
//   its FIFO is not empty and its PE row is ready. A per-lane done bit reports
//   that every requested pop has been issued.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   abort_i        synchronous clear of every lane to IDLE
//   need_pop_i     per-lane load strobe (one-cycle pulse)
//   pop_num_i      per-lane pop count, sampled with need_pop_i
//   fifo_empty_i   per-lane FIFO empty
//   pe_ready_i     per-lane PE row ready
//   fifo_pop_o     per-lane pop strobe (combinational from state and inputs)
//   done_matrix_o  per-lane "all requested pops issued" (decode of state)
//   all_done_o     AND of done_matrix_o
//   reload_err_o   one-cycle pulse: need_pop arrived on a lane still popping
// ---------------------------------------------------------------------------
module fifo_pop_ctrl #(
    parameter int NUM_FIFO = 32,
    parameter int CNT_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            abort_i,
    input  logic [NUM_FIFO-1:0]             need_pop_i,
    input  logic [NUM_FIFO-1:0][CNT_W-1:0]  pop_num_i,
    input  logic [NUM_FIFO-1:0]             fifo_empty_i,
    input  logic [NUM_FIFO-1:0]             pe_ready_i,
    output logic [NUM_FIFO-1:0]             fifo_pop_o,
    output logic [NUM_FIFO-1:0]             done_matrix_o,
    output logic                            all_done_o,
    output logic                            reload_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    lane_state_t          state [NUM_FIFO];
    logic [CNT_W-1:0]     cnt   [NUM_FIFO];
    logic [NUM_FIFO-1:0]  reload_hit;

    // Output decode and reload detection from the lane registers.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the loop leaves a bit unassigned and infers a latch.
        fifo_pop_o    = '0;
        done_matrix_o = '0;
        reload_hit    = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            fifo_pop_o[k]    = (state[k] == POP) & ~fifo_empty_i[k] & pe_ready_i[k];
            done_matrix_o[k] = (state[k] == DONE);
            reload_hit[k]    = need_pop_i[k] & (state[k] == POP);
        end
    end

    assign all_done_o = &done_matrix_o;

    // Lane FSMs and counters. Priority: rst > abort > load > pop/decrement.
    // A pop that is live during an abort cycle still reaches the FIFO, but the
    // count is cleared anyway.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: cnt is control state that decides when a lane finishes, so
        // every entry is reset, unlike a datapath RAM that would need no reset.
        if (rst) begin
            for (int k = 0; k < NUM_FIFO; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
            reload_err_o <= 1'b0;
        end else if (abort_i) begin
            for (int k = 0; k < NUM_FIFO; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
            reload_err_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so each lane reads
            // its pre-edge cnt and state regardless of statement order.
            reload_err_o <= |reload_hit;
            for (int k = 0; k < NUM_FIFO; k++) begin
                if (need_pop_i[k]) begin
                    // Any load, even one in POP, discards the remaining pops.
                    if (pop_num_i[k] == '0) begin
                        state[k] <= DONE;
                        cnt[k]   <= '0;
                    end else begin
                        state[k] <= POP;
                        cnt[k]   <= pop_num_i[k];
                    end
                end else if (fifo_pop_o[k] && (cnt[k] != '0)) begin
                    cnt[k] <= cnt[k] - CNT_W'(1);
                    if (cnt[k] == CNT_W'(1)) begin
                        state[k] <= DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_pop_ctrl
//   Self-checking bench for fifo_pop_ctrl. A model keeps, per lane, the number
//   of pops still owed. A compare process checks every DUT output against it
//   on each falling edge. Directed scenarios pin exact cycles and pop totals
//   with literal expectations. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_fifo_pop_ctrl;

    localparam int NF = 32;
    localparam int CW = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   abort_i = 1'b0;
    logic [NF-1:0]          need_pop_i = '0;
    logic [NF-1:0][CW-1:0]  pop_num_i = '0;
    logic [NF-1:0]          fifo_empty_i = '0;
    logic [NF-1:0]          pe_ready_i = '1;
    logic [NF-1:0]          fifo_pop_o;
    logic [NF-1:0]          done_matrix_o;
    logic                   all_done_o;
    logic                   reload_err_o;

    fifo_pop_ctrl #(.NUM_FIFO(NF), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .abort_i       (abort_i),
        .need_pop_i    (need_pop_i),
        .pop_num_i     (pop_num_i),
        .fifo_empty_i  (fifo_empty_i),
        .pe_ready_i    (pe_ready_i),
        .fifo_pop_o    (fifo_pop_o),
        .done_matrix_o (done_matrix_o),
        .all_done_o    (all_done_o),
        .reload_err_o  (reload_err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pops still owed per lane, whether the lane is popping, and
    // whether it has finished its last request.
    longint        m_rem [NF];
    logic [NF-1:0] m_act;
    logic [NF-1:0] m_done;
    logic          m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NF; k++) m_rem[k] <= 0;
            m_act  <= '0;
            m_done <= '0;
            m_err  <= 1'b0;
        end else if (abort_i) begin
            for (int k = 0; k < NF; k++) m_rem[k] <= 0;
            m_act  <= '0;
            m_done <= '0;
            m_err  <= 1'b0;
        end else begin
            m_err <= |(need_pop_i & m_act);
            for (int k = 0; k < NF; k++) begin
                if (need_pop_i[k]) begin
                    m_rem[k]  <= longint'(pop_num_i[k]);
                    m_act[k]  <= (pop_num_i[k] != 0);
                    m_done[k] <= (pop_num_i[k] == 0);
                end else if (m_act[k] && !fifo_empty_i[k] && pe_ready_i[k]) begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_act[k]  <= 1'b0;
                        m_done[k] <= 1'b1;
                    end
                end
            end
        end
    end

    wire [NF-1:0] exp_pop = m_act & ~fifo_empty_i & pe_ready_i;

    // Per-lane count of pops actually issued by the DUT.
    int pop_count [NF];
    initial for (int k = 0; k < NF; k++) pop_count[k] = 0;

    always @(negedge clk) begin
        check("cmp_pop",      fifo_pop_o,           exp_pop);
        check("cmp_done",     done_matrix_o,        m_done);
        check("cmp_all_done", {31'd0, all_done_o},  {31'd0, &m_done});
        check("cmp_rld_err",  {31'd0, reload_err_o}, {31'd0, m_err});
        for (int k = 0; k < NF; k++) pop_count[k] <= pop_count[k] + int'(fifo_pop_o[k]);
    end

    int snap [NF];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_snap();
        for (int k = 0; k < NF; k++) snap[k] = pop_count[k];
    endtask

    initial begin
        // Reset state, checked while reset is held before any edge.
        #2;
        check("rst_pop",      fifo_pop_o,            32'h0);
        check("rst_done",     done_matrix_o,         32'h0);
        check("rst_all_done", {31'd0, all_done_o},   32'h0);
        check("rst_rld_err",  {31'd0, reload_err_o}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: pointwise, every lane pops once.
        take_snap();
        need_pop_i = '1;
        for (int k = 0; k < NF; k++) pop_num_i[k] = 1;
        tick();
        need_pop_i = '0;
        check("pw_pop_t1", fifo_pop_o, 32'hFFFF_FFFF);
        tick();
        check("pw_done_t2", done_matrix_o, 32'hFFFF_FFFF);
        check("pw_all_t2",  {31'd0, all_done_o}, 32'h1);
        check("pw_nopop_t2", fifo_pop_o, 32'h0);

        // 2: depthwise counts 3,3,3,6,...,30,30,30 and two zero lanes.
        take_snap();
        need_pop_i = '1;
        for (int k = 0; k < NF; k++) pop_num_i[k] = (k < 30) ? CW'(3 * (k / 3 + 1)) : '0;
        tick();
        need_pop_i = '0;
        for (int c = 1; c <= 31; c++) begin
            if (c == 1)  check("dw_done_t1",    done_matrix_o, 32'hC000_0000);
            if (c == 3)  check("dw_l0_t3",      {31'd0, done_matrix_o[0]}, 32'h0);
            if (c == 4)  check("dw_l0_t4",      {31'd0, done_matrix_o[0]}, 32'h1);
            if (c == 30) check("dw_l29_t30",    {31'd0, done_matrix_o[29]}, 32'h0);
            if (c == 31) check("dw_all_t31",    {31'd0, all_done_o}, 32'h1);
            if (c < 31) tick();
        end
        check("dw_cnt_l0",  pop_count[0]  - snap[0],  32'd3);
        check("dw_cnt_l29", pop_count[29] - snap[29], 32'd30);
        check("dw_cnt_l30", pop_count[30] - snap[30], 32'd0);

        // 3: lane 5 stalled by an empty FIFO for four cycles.
        take_snap();
        need_pop_i[5] = 1'b1;
        pop_num_i[5]  = 4;
        fifo_empty_i[5] = 1'b1;
        tick();
        need_pop_i = '0;
        check("es_done_t1", done_matrix_o, 32'hFFFF_FFDF);
        for (int c = 1; c <= 4; c++) begin
            check("es_stall", {31'd0, fifo_pop_o[5]}, 32'h0);
            tick();
        end
        fifo_empty_i[5] = 1'b0;
        #1;
        for (int c = 5; c <= 8; c++) begin
            check("es_pop", {31'd0, fifo_pop_o[5]}, 32'h1);
            tick();
        end
        check("es_done_t9", done_matrix_o, 32'hFFFF_FFFF);
        check("es_cnt_l5",  pop_count[5] - snap[5], 32'd4);
        check("es_cnt_l4",  pop_count[4] - snap[4], 32'd0);

        // 4: lane 0 with alternating PE ready.
        take_snap();
        need_pop_i[0] = 1'b1;
        pop_num_i[0]  = 3;
        tick();
        need_pop_i = '0;
        for (int c = 1; c <= 6; c++) begin
            pe_ready_i[0] = c[0];
            #1;
            if (c == 5) check("bp_l0_t5", {31'd0, done_matrix_o[0]}, 32'h0);
            if (c == 6) check("bp_l0_t6", {31'd0, done_matrix_o[0]}, 32'h1);
            if (c < 6) tick();
        end
        check("bp_cnt_l0", pop_count[0] - snap[0], 32'd3);
        pe_ready_i = '1;

        // 5: lane 2 reloaded after four pops.
        take_snap();
        need_pop_i[2] = 1'b1;
        pop_num_i[2]  = 10;
        tick();
        need_pop_i = '0;
        tick(); tick(); tick();
        need_pop_i[2] = 1'b1;
        pop_num_i[2]  = 2;
        tick();
        need_pop_i = '0;
        check("rl_err_pulse", {31'd0, reload_err_o}, 32'h1);
        tick();
        check("rl_err_clear", {31'd0, reload_err_o}, 32'h0);
        tick();
        check("rl_done_l2", {31'd0, done_matrix_o[2]}, 32'h1);
        check("rl_cnt_l2",  pop_count[2] - snap[2], 32'd6);

        // 6a: asynchronous reset in the middle of popping.
        need_pop_i = '1;
        for (int k = 0; k < NF; k++) pop_num_i[k] = 20;
        tick();
        need_pop_i = '0;
        tick(); tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pop",      fifo_pop_o,            32'h0);
        check("ar_done",     done_matrix_o,         32'h0);
        check("ar_all_done", {31'd0, all_done_o},   32'h0);
        tick(); tick();
        rst = 1'b0;
        take_snap();
        tick(); tick(); tick(); tick();
        check("ar_no_pops", pop_count[0] - snap[0], 32'd0);

        // 6b: synchronous abort in the middle of popping.
        need_pop_i = '1;
        tick();
        need_pop_i = '0;
        tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("ab_pop",  fifo_pop_o,    32'h0);
        check("ab_done", done_matrix_o, 32'h0);
        take_snap();
        tick(); tick(); tick();
        check("ab_no_pops", pop_count[7] - snap[7], 32'd0);

        // Randomized phase against the model.
        for (int c = 0; c < 400; c++) begin
            need_pop_i   = $urandom & $urandom & $urandom;
            for (int k = 0; k < NF; k++) pop_num_i[k] = CW'($urandom_range(0, 6));
            fifo_empty_i = $urandom & $urandom;
            pe_ready_i   = $urandom | $urandom;
            abort_i      = ($urandom_range(0, 99) == 0);
            tick();
        end
        abort_i    = 1'b0;
        need_pop_i = '1;
        pop_num_i  = '0;
        tick();
        need_pop_i = '0;
        check("rnd_final_all", {31'd0, all_done_o}, 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
